// File: rtl/fetch_mem_if_if.sv
// rtl/fetch_mem_if_if.sv - fetch-side and instruction-bus signals of fetch_mem_if
// slave is the fetch_mem_if view; master is the fetch stage plus bus seen from outside.
interface fetch_mem_if_if #(
  parameter int ADDR_W = 30
);
  logic              ins_req;
  logic [ADDR_W-1:0] addr;
  logic              flush;
  logic              ins_res;
  logic [31:0]       data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              bus_err;

  modport slave (
    input  ins_req, addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output ins_res, data, mem_req, mem_addr, bus_err
  );

  modport master (
    output ins_req, addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  ins_res, data, mem_req, mem_addr, bus_err
  );
endinterface

// File: rtl/fetch_mem_if.sv
// rtl/fetch_mem_if.sv - one bus read per fetch request, flush-aware, one word in flight
// Define FETCH_MEM_IF_TIMEOUT_EN to add the DATA-state watchdog that raises bus_err.
module fetch_mem_if #(
  parameter int          ADDR_W   = 30,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'h0000_0000
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst_n,
  fetch_mem_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state_q;
  logic              ins_res_q;
  logic              mem_req_q;
  logic              drop_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rvalid;

`ifdef FETCH_MEM_IF_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  logic             late_q;

  // After a timeout the bus still owes one beat; swallow it so it is not
  // mistaken for the next transaction's data.
  assign rvalid      = bus.mem_rvalid && !late_q;
  assign bus.bus_err = bus_err_q;
`else
  logic unused_cfg;

  assign rvalid      = bus.mem_rvalid;
  assign bus.bus_err = 1'b0;
  assign unused_cfg  = ^{ERR_WORD, 1'(TIMEOUT)};
`endif

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= IDLE;
      ins_res_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      drop_q     <= 1'b0;
      data_q     <= 32'h0;
      mem_addr_q <= '0;
`ifdef FETCH_MEM_IF_TIMEOUT_EN
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      late_q     <= 1'b0;
`endif
    end else begin
      ins_res_q <= 1'b0;
`ifdef FETCH_MEM_IF_TIMEOUT_EN
      bus_err_q <= 1'b0;
      if (bus.mem_rvalid && late_q) begin
        late_q <= 1'b0;
      end
`endif
      case (state_q)
        IDLE: begin
          if (bus.ins_req && !bus.flush) begin
            mem_addr_q <= bus.addr;
            mem_req_q  <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          // Read data cannot arrive before DATA, so rvalid is not looked at here.
          if (bus.flush) begin
            drop_q <= 1'b1;
          end
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= DATA;
`ifdef FETCH_MEM_IF_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        DATA: begin
          if (rvalid) begin
            if (drop_q || bus.flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              data_q    <= bus.mem_rdata;
              ins_res_q <= 1'b1;
              state_q   <= RESP;
            end
          end else begin
            if (bus.flush) begin
              drop_q <= 1'b1;
            end
`ifdef FETCH_MEM_IF_TIMEOUT_EN
            if (cnt_q == CNT_W'(TIMEOUT)) begin
              bus_err_q <= 1'b1;
              data_q    <= ERR_WORD;
              late_q    <= 1'b1;
              cnt_q     <= '0;
              if (drop_q || bus.flush) begin
                drop_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                ins_res_q <= 1'b1;
                state_q   <= RESP;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ins_res  = ins_res_q;
  assign bus.data     = data_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_mem_if.sv
// tb/tb_fetch_mem_if.sv - vector table plus scoreboard bench for fetch_mem_if
// Honours FETCH_MEM_IF_TIMEOUT_EN for the watchdog sequence.
module tb_fetch_mem_if;

  logic cpu_clk;
  logic cpu_rst_n;

  fetch_mem_if_if #(.ADDR_W(30)) bus ();

  fetch_mem_if #(.ADDR_W(30), .TIMEOUT(255), .ERR_WORD(32'h0000_0000)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .bus      (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [29:0] addr;
    int          gw;     // grant wait cycles
    int          rw;     // rvalid wait cycles after grant
    logic [31:0] rdata;
    int          fl;     // 0 none, 1 flush in ADDR, 2 flush in DATA, 3 flush with grant
    bit          hold;   // keep ins_req high into the next vector
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_res   = 0;
  int          n_err   = 0;
  int          n_push  = 0;
  bit          prev_res = 1'b0;
  logic [31:0] exp_q[$];
  logic [29:0] gaddr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard side: every ins_res pops one expected word.
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      if (bus.ins_res) begin
        n_res++;
        chk("res_pulse_width", 64'(prev_res), 64'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_res actual data=%0h required no ins_res at %0t", bus.data, $time);
        end else begin
          chk("res_data", bus.data, exp_q.pop_front());
        end
      end
      if (bus.bus_err) n_err++;
      prev_res = bus.ins_res;
    end else begin
      prev_res = 1'b0;
    end
  end

  task automatic run_txn(input vec_t v, output int lat, output int nreq);
    bit dropped;
    lat  = 0;
    nreq = 0;
    dropped = (v.fl != 0);
    bus.flush   = 1'b0;
    bus.ins_req = 1'b1;
    bus.addr    = v.addr;
    do begin
      @(negedge cpu_clk);
      lat++;
      nreq++;
    end while (!bus.mem_req && nreq < 8);
    chk("req_seen", 64'(bus.mem_req), 64'd1);
    for (int k = 0; k <= v.gw; k++) begin
      if (k > 0) begin
        @(negedge cpu_clk);
        lat++;
      end
      chk("req_hold", 64'(bus.mem_req), 64'd1);
      chk("addr_hold", 64'(bus.mem_addr), 64'(v.addr));
      bus.flush = (v.fl == 1 && k == 0);
      if (k == v.gw) begin
        bus.mem_gnt = 1'b1;
        if (v.fl == 3) bus.flush = 1'b1;
        gaddr.push_back(bus.mem_addr);
      end
    end
    for (int k = 0; k <= v.rw; k++) begin
      @(negedge cpu_clk);
      lat++;
      bus.mem_gnt = 1'b0;
      if (k == 0) chk("req_one_grant", 64'(bus.mem_req), 64'd0);
      bus.flush = (v.fl == 2 && k == 0);
      if (k == v.rw) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
        if (!dropped) begin
          exp_q.push_back(v.rdata);
          n_push++;
        end
      end
    end
    @(negedge cpu_clk);
    lat++;
    bus.mem_rvalid = 1'b0;
    bus.flush      = 1'b0;
    if (dropped) begin
      chk("no_res_on_drop", 64'(bus.ins_res), 64'd0);
      bus.ins_req = 1'b0;
      repeat (3) @(negedge cpu_clk);
    end else begin
      chk("res_strobe", 64'(bus.ins_res), 64'd1);
      if (!v.hold) bus.ins_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, nreq, res0, cnt;
    bit seen;
    vec_t v;

    vecs[0]  = '{30'h10,       0, 0, 32'hA5A5_1234, 0, 1'b0};
    vecs[1]  = '{30'h10,       4, 0, 32'h1111_2222, 0, 1'b0};
    vecs[2]  = '{30'h20,       0, 2, 32'hDEAD_BEEF, 2, 1'b0};
    vecs[3]  = '{30'h40,       0, 0, 32'h4040_4040, 0, 1'b0};
    vecs[4]  = '{30'h50,       1, 1, 32'hCAFE_F00D, 1, 1'b0};
    vecs[5]  = '{30'h60,       0, 0, 32'h5A5A_5A5A, 3, 1'b0};
    vecs[6]  = '{30'h70,       0, 0, 32'h7777_0000, 2, 1'b0};
    vecs[7]  = '{30'h0,        0, 0, 32'h0000_0A00, 0, 1'b1};
    vecs[8]  = '{30'h1,        2, 1, 32'h0000_0A01, 0, 1'b1};
    vecs[9]  = '{30'h2,        0, 3, 32'h0000_0A02, 0, 1'b0};
    vecs[10] = '{30'h3FFF_FFFF, 1, 0, 32'hFFFF_0000, 0, 1'b0};
    vecs[11] = '{30'h80,       0, 1, 32'h8765_4321, 0, 1'b0};

    cpu_rst_n      = 1'b0;
    bus.ins_req    = 1'b0;
    bus.addr       = '0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (2) @(negedge cpu_clk);
    chk("rst_ins_res", 64'(bus.ins_res), 64'd0);
    chk("rst_data", 64'(bus.data), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_bus_err", 64'(bus.bus_err), 64'd0);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);

    for (int i = 0; i < NV; i++) begin
      if (i == 7) gaddr.delete();
      res0 = n_res;
      run_txn(vecs[i], lat, nreq);
      if (i == 0) chk("latency_zero_wait", 64'(lat), 64'd3);
      if (vecs[i].fl == 0)
        chk("latency_after_req", 64'(lat - nreq), 64'(vecs[i].gw + vecs[i].rw + 2));
      if (i == 9) begin
        chk("b2b_grants", 64'(gaddr.size()), 64'd3);
        for (int j = 0; j < 3 && j < gaddr.size(); j++)
          chk("b2b_addr", 64'(gaddr[j]), 64'(vecs[7 + j].addr));
      end
    end

    // Flush in IDLE blocks issue for that cycle only.
    @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'h90;
    bus.flush   = 1'b1;
    @(negedge cpu_clk);
    chk("idle_flush_blocks", 64'(bus.mem_req), 64'd0);
    v = '{30'h90, 0, 0, 32'h9090_0909, 0, 1'b0};
    run_txn(v, lat, nreq);
    chk("idle_flush_then_issue", 64'(nreq), 64'd1);

    // Reset while mem_req is up: outputs clear without a clock edge.
    repeat (2) @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'h77;
    @(negedge cpu_clk);
    chk("pre_rst_req", 64'(bus.mem_req), 64'd1);
    #2 cpu_rst_n = 1'b0;
    #1;
    chk("async_rst_req", 64'(bus.mem_req), 64'd0);
    chk("async_rst_res", 64'(bus.ins_res), 64'd0);
    chk("async_rst_data", 64'(bus.data), 64'd0);
    @(negedge cpu_clk);
    bus.ins_req = 1'b0;
    cpu_rst_n   = 1'b1;
    @(negedge cpu_clk);
    chk("post_rst_idle", 64'(bus.mem_req), 64'd0);
    v = '{30'h77, 0, 0, 32'h7777_7777, 0, 1'b0};
    run_txn(v, lat, nreq);
    chk("post_rst_first_issue", 64'(nreq), 64'd1);

    // Stalled read data.
    repeat (2) @(negedge cpu_clk);
    bus.ins_req = 1'b1;
    bus.addr    = 30'hA0;
    @(negedge cpu_clk);
    chk("stall_req", 64'(bus.mem_req), 64'd1);
    bus.mem_gnt = 1'b1;
    @(negedge cpu_clk);
    bus.mem_gnt = 1'b0;
`ifdef FETCH_MEM_IF_TIMEOUT_EN
    exp_q.push_back(32'h0000_0000);
    n_push++;
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 300) begin
      @(negedge cpu_clk);
      cnt++;
      if (bus.bus_err) begin
        seen = 1'b1;
        chk("timeout_res", 64'(bus.ins_res), 64'd1);
        chk("timeout_data", 64'(bus.data), 64'd0);
      end
    end
    chk("timeout_bus_err_seen", 64'(seen), 64'd1);
    bus.ins_req = 1'b0;
    repeat (2) @(negedge cpu_clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    @(negedge cpu_clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge cpu_clk);
    v = '{30'hB0, 0, 1, 32'hB0B0_B0B0, 0, 1'b0};
    run_txn(v, lat, nreq);
`else
    seen = 1'b0;
    res0 = n_res;
    repeat (300) begin
      @(negedge cpu_clk);
      if (bus.bus_err) seen = 1'b1;
    end
    chk("no_timeout_bus_err", 64'(seen), 64'd0);
    chk("still_waiting", 64'(n_res - res0), 64'd0);
    chk("still_no_req", 64'(bus.mem_req), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    n_push++;
    @(negedge cpu_clk);
    bus.mem_rvalid = 1'b0;
    bus.ins_req    = 1'b0;
    chk("late_word_returned", 64'(bus.ins_res), 64'd1);
`endif

    repeat (4) @(negedge cpu_clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("res_count", 64'(n_res), 64'(n_push));
`ifdef FETCH_MEM_IF_TIMEOUT_EN
    chk("bus_err_count", 64'(n_err), 64'd1);
`else
    chk("bus_err_count", 64'(n_err), 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
